// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/WB/EX inputs and the ID/EX-facing outputs.
interface id_stage_if #(
   parameter int WORD_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic [WORD_WIDTH-1:0] IR_in;
   logic [WORD_WIDTH-1:0] PC4_in;
   logic                  IF_valid;
   logic                  flush;
   logic                  RegWrite_WB;
   logic [4:0]            WriteReg_WB;
   logic [WORD_WIDTH-1:0] WriteData_WB;
   logic                  MemRead_EX;
   logic [4:0]            Rt_EX;
   logic [WORD_WIDTH-1:0] A_0;
   logic [WORD_WIDTH-1:0] B_0;
   logic [5:0]            Out31_26_0;
   logic [5:0]            Out5_0_0;
   logic [4:0]            Out25_21_0;
   logic [4:0]            Out20_16_0;
   logic [4:0]            Out15_11_0;
   logic [4:0]            Out10_6_0;
   logic [WORD_WIDTH-1:0] PC4_out;
   logic                  valid_out;
   logic                  stall;
   logic [CNT_WIDTH-1:0]  stall_cnt;

   modport master (
      output IR_in, PC4_in, IF_valid, flush,
      output RegWrite_WB, WriteReg_WB, WriteData_WB,
      output MemRead_EX, Rt_EX,
      input  A_0, B_0, Out31_26_0, Out5_0_0,
      input  Out25_21_0, Out20_16_0, Out15_11_0, Out10_6_0,
      input  PC4_out, valid_out, stall, stall_cnt
   );

   modport slave (
      input  IR_in, PC4_in, IF_valid, flush,
      input  RegWrite_WB, WriteReg_WB, WriteData_WB,
      input  MemRead_EX, Rt_EX,
      output A_0, B_0, Out31_26_0, Out5_0_0,
      output Out25_21_0, Out20_16_0, Out15_11_0, Out10_6_0,
      output PC4_out, valid_out, stall, stall_cnt
   );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID latch, regfile with WB bypass,
// load-use hazard detection and NOP bubble injection.
module id_stage #(
   parameter int WORD_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input logic       CLK,
   input logic       RST_N,
   id_stage_if.slave bus
);
   logic [WORD_WIDTH-1:0] ir_q, ir_d;
   logic [WORD_WIDTH-1:0] pc4_q, pc4_d;
   logic                  valid_q, valid_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] rf_q [REG_COUNT];

   logic [5:0]            opcode, funct;
   logic [4:0]            rs, rt, rd, shamt;
   logic                  wr_en, uses_rt, stall;
   logic [WORD_WIDTH-1:0] rs_val, rt_val;

   assign opcode = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign shamt  = ir_q[10:6];
   assign funct  = ir_q[5:0];

   assign wr_en = bus.RegWrite_WB & (bus.WriteReg_WB != 5'd0);

   // Write-before-read: a same-cycle WB to the read address wins.
   always_comb begin
      rs_val = rf_q[rs];
      rt_val = rf_q[rt];
      if (wr_en && bus.WriteReg_WB == rs) rs_val = bus.WriteData_WB;
      if (wr_en && bus.WriteReg_WB == rt) rt_val = bus.WriteData_WB;
      if (rs == 5'd0) rs_val = '0;
      if (rt == 5'd0) rt_val = '0;
   end

   assign uses_rt = (opcode == 6'd0) | (opcode == 6'd4) |
                    (opcode == 6'd5) | (opcode == 6'd43);

   assign stall = valid_q & bus.MemRead_EX & (bus.Rt_EX != 5'd0) &
                  ((bus.Rt_EX == rs) | (uses_rt & (bus.Rt_EX == rt)));

   always_comb begin
      ir_d    = bus.IR_in;
      pc4_d   = bus.PC4_in;
      valid_d = bus.IF_valid;
      if (bus.flush) begin
         ir_d    = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (stall) begin
         ir_d    = ir_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && !bus.flush && cnt_q != {CNT_WIDTH{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ir_q    <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ir_q    <= ir_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
      end else if (wr_en) begin
         rf_q[bus.WriteReg_WB] <= bus.WriteData_WB;
      end
   end

   // Bubble is all-zero: sll $0,$0,0 with valid cleared.
   assign bus.A_0        = stall ? '0 : rs_val;
   assign bus.B_0        = stall ? '0 : rt_val;
   assign bus.Out31_26_0 = stall ? '0 : opcode;
   assign bus.Out25_21_0 = stall ? '0 : rs;
   assign bus.Out20_16_0 = stall ? '0 : rt;
   assign bus.Out15_11_0 = stall ? '0 : rd;
   assign bus.Out10_6_0  = stall ? '0 : shamt;
   assign bus.Out5_0_0   = stall ? '0 : funct;
   assign bus.valid_out  = stall ? 1'b0 : valid_q;
   assign bus.PC4_out    = pc4_q;
   assign bus.stall      = stall;
   assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table via scoreboard
// plus hand sequences for bypass, hazards, flush, reset, saturation.
module tb_id_stage;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   logic [31:0] mrf [32];

   id_stage_if #(.WORD_WIDTH(32), .CNT_WIDTH(16)) bus ();

   id_stage #(.WORD_WIDTH(32), .REG_COUNT(32), .CNT_WIDTH(16)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc4;
      logic        ifv;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
   } vec_t;

   typedef struct {
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh;
      logic [31:0] a, b, pc4;
      logic        v;
   } exp_t;

   vec_t vecs [6];
   exp_t sb [$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] regval(input int i);
      if (i == 9) return 32'd5;
      if (i == 10) return 32'd7;
      return 32'h1000 + i;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".stall"}, {31'd0, bus.stall}, 32'd1);
      check({tag, ".A"}, bus.A_0, 32'd0);
      check({tag, ".B"}, bus.B_0, 32'd0);
      check({tag, ".rs"}, {27'd0, bus.Out25_21_0}, 32'd0);
      check({tag, ".rt"}, {27'd0, bus.Out20_16_0}, 32'd0);
      check({tag, ".fn"}, {26'd0, bus.Out5_0_0}, 32'd0);
      check({tag, ".v"}, {31'd0, bus.valid_out}, 32'd0);
   endtask

   initial begin
      exp_t e;
      vecs[0] = '{32'h012A4020, 32'h404, 1'b1, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20};
      vecs[1] = '{32'h8CC50000, 32'h408, 1'b1, 6'h23, 5'd6, 5'd5, 5'd0, 5'd0, 6'h00};
      vecs[2] = '{32'h00021900, 32'h40C, 1'b1, 6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00};
      vecs[3] = '{32'hFFFFFFFF, 32'h410, 1'b1, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F};
      vecs[4] = '{32'h012A4020, 32'h414, 1'b0, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20};
      vecs[5] = '{32'hAC270008, 32'h418, 1'b1, 6'h2B, 5'd1, 5'd7, 5'd0, 5'd0, 6'h08};

      bus.IR_in = 32'h012A4020;
      bus.PC4_in = 32'h404;
      bus.IF_valid = 1'b1;
      bus.flush = 1'b0;
      bus.RegWrite_WB = 1'b0;
      bus.WriteReg_WB = 5'd0;
      bus.WriteData_WB = 32'd0;
      bus.MemRead_EX = 1'b0;
      bus.Rt_EX = 5'd0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;

      #12;
      check("rst.stall", {31'd0, bus.stall}, 32'd0);
      check("rst.cnt", {16'd0, bus.stall_cnt}, 32'd0);
      check("rst.valid", {31'd0, bus.valid_out}, 32'd0);
      check("rst.pc4", bus.PC4_out, 32'd0);
      check("rst.fn", {26'd0, bus.Out5_0_0}, 32'd0);
      RST_N = 1'b1;
      tick();

      // Preload registers through WB; also try writing $0.
      bus.IF_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.RegWrite_WB = 1'b1;
         bus.WriteReg_WB = 5'(i);
         bus.WriteData_WB = (i == 0) ? 32'hBAD0BAD0 : regval(i);
         if (i != 0) mrf[i] = regval(i);
         tick();
      end
      bus.RegWrite_WB = 1'b0;

      // Vector table, expectations queued at drive time.
      for (int k = 0; k < 6; k++) begin
         bus.IR_in = vecs[k].ir;
         bus.PC4_in = vecs[k].pc4;
         bus.IF_valid = vecs[k].ifv;
         e.op = vecs[k].op;
         e.fn = vecs[k].fn;
         e.rs = vecs[k].rs;
         e.rt = vecs[k].rt;
         e.rd = vecs[k].rd;
         e.sh = vecs[k].sh;
         e.a = mrf[vecs[k].rs];
         e.b = mrf[vecs[k].rt];
         e.pc4 = vecs[k].pc4;
         e.v = vecs[k].ifv;
         sb.push_back(e);
         tick();
         if (sb.size() == 0) begin
            check("sb.empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check($sformatf("v%0d.op", k), {26'd0, bus.Out31_26_0}, {26'd0, e.op});
            check($sformatf("v%0d.rs", k), {27'd0, bus.Out25_21_0}, {27'd0, e.rs});
            check($sformatf("v%0d.rt", k), {27'd0, bus.Out20_16_0}, {27'd0, e.rt});
            check($sformatf("v%0d.rd", k), {27'd0, bus.Out15_11_0}, {27'd0, e.rd});
            check($sformatf("v%0d.sh", k), {27'd0, bus.Out10_6_0}, {27'd0, e.sh});
            check($sformatf("v%0d.fn", k), {26'd0, bus.Out5_0_0}, {26'd0, e.fn});
            check($sformatf("v%0d.A", k), bus.A_0, e.a);
            check($sformatf("v%0d.B", k), bus.B_0, e.b);
            check($sformatf("v%0d.pc4", k), bus.PC4_out, e.pc4);
            check($sformatf("v%0d.v", k), {31'd0, bus.valid_out}, {31'd0, e.v});
            check($sformatf("v%0d.stall", k), {31'd0, bus.stall}, 32'd0);
         end
      end

      // Same-cycle WB bypass on rs=$3.
      bus.IR_in = 32'h00600000;
      bus.IF_valid = 1'b1;
      tick();
      check("byp.pre", bus.A_0, mrf[3]);
      bus.RegWrite_WB = 1'b1;
      bus.WriteReg_WB = 5'd3;
      bus.WriteData_WB = 32'hDEADBEEF;
      #1;
      check("byp.same", bus.A_0, 32'hDEADBEEF);
      tick();
      mrf[3] = 32'hDEADBEEF;
      bus.RegWrite_WB = 1'b0;
      #1;
      check("byp.after", bus.A_0, mrf[3]);

      // Bypass to $0 is ignored.
      bus.IR_in = 32'h00000000;
      tick();
      bus.RegWrite_WB = 1'b1;
      bus.WriteReg_WB = 5'd0;
      bus.WriteData_WB = 32'h12345678;
      #1;
      check("r0.same", bus.A_0, 32'd0);
      tick();
      bus.RegWrite_WB = 1'b0;
      #1;
      check("r0.after", bus.A_0, 32'd0);

      // Load-use on rs: one stall cycle, IR held.
      bus.IR_in = 32'h00853020;
      bus.PC4_in = 32'h500;
      tick();
      bus.MemRead_EX = 1'b1;
      bus.Rt_EX = 5'd4;
      bus.IR_in = 32'hFFFFFFFF;
      bus.PC4_in = 32'h999;
      #1;
      check_bubble("lu");
      check("lu.pc4", bus.PC4_out, 32'h500);
      tick();
      exp_cnt++;
      check("lu.cnt", {16'd0, bus.stall_cnt}, exp_cnt);
      bus.MemRead_EX = 1'b0;
      #1;
      check("lu2.stall", {31'd0, bus.stall}, 32'd0);
      check("lu2.rs", {27'd0, bus.Out25_21_0}, 32'd4);
      check("lu2.fn", {26'd0, bus.Out5_0_0}, 32'h20);
      check("lu2.A", bus.A_0, mrf[4]);
      check("lu2.B", bus.B_0, mrf[5]);
      check("lu2.v", {31'd0, bus.valid_out}, 32'd1);
      check("lu2.cnt", {16'd0, bus.stall_cnt}, exp_cnt);

      // rt hazard on an R-type.
      bus.MemRead_EX = 1'b1;
      bus.Rt_EX = 5'd5;
      #1;
      check("rt.stall", {31'd0, bus.stall}, 32'd1);
      bus.MemRead_EX = 1'b0;

      // lw does not read rt; rs still hazards.
      bus.IR_in = 32'h8CC50000;
      tick();
      bus.MemRead_EX = 1'b1;
      bus.Rt_EX = 5'd5;
      #1;
      check("lw.rt", {31'd0, bus.stall}, 32'd0);
      bus.Rt_EX = 5'd6;
      #1;
      check("lw.rs", {31'd0, bus.stall}, 32'd1);
      bus.MemRead_EX = 1'b0;

      // Rt_EX=0 never stalls even when fields are 0.
      bus.IR_in = 32'h00000000;
      tick();
      bus.MemRead_EX = 1'b1;
      bus.Rt_EX = 5'd0;
      #1;
      check("rt0.stall", {31'd0, bus.stall}, 32'd0);
      bus.MemRead_EX = 1'b0;

      // flush beats stall; counter not bumped.
      bus.IR_in = 32'h00853020;
      bus.PC4_in = 32'h600;
      tick();
      bus.MemRead_EX = 1'b1;
      bus.Rt_EX = 5'd4;
      #1;
      check("fs.stall", {31'd0, bus.stall}, 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.MemRead_EX = 1'b0;
      #1;
      check("fs.v", {31'd0, bus.valid_out}, 32'd0);
      check("fs.fn", {26'd0, bus.Out5_0_0}, 32'd0);
      check("fs.rs", {27'd0, bus.Out25_21_0}, 32'd0);
      check("fs.pc4", bus.PC4_out, 32'd0);
      check("fs.cnt", {16'd0, bus.stall_cnt}, exp_cnt);

      // Asynchronous reset in the middle of a stall.
      tick();
      bus.MemRead_EX = 1'b1;
      bus.Rt_EX = 5'd4;
      tick();
      exp_cnt++;
      check("mr.cnt", {16'd0, bus.stall_cnt}, exp_cnt);
      check("mr.stall", {31'd0, bus.stall}, 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("mr.stall0", {31'd0, bus.stall}, 32'd0);
      check("mr.cnt0", {16'd0, bus.stall_cnt}, 32'd0);
      check("mr.A", bus.A_0, 32'd0);
      check("mr.v", {31'd0, bus.valid_out}, 32'd0);
      check("mr.pc4", bus.PC4_out, 32'd0);
      check("mr.fn", {26'd0, bus.Out5_0_0}, 32'd0);
      tick();
      RST_N = 1'b1;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      bus.MemRead_EX = 1'b0;
      bus.IR_in = 32'h012A4020;
      tick();
      check("pr.A", bus.A_0, mrf[9]);
      check("pr.B", bus.B_0, mrf[10]);
      check("pr.rd", {27'd0, bus.Out15_11_0}, 32'd8);

      // Counter saturation.
      bus.IR_in = 32'h00853020;
      tick();
      bus.MemRead_EX = 1'b1;
      bus.Rt_EX = 5'd4;
      repeat (65539) @(posedge CLK);
      #1;
      check("sat.cnt", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
      check("sat.stall", {31'd0, bus.stall}, 32'd1);
      bus.MemRead_EX = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the 5-stage MIPS pipeline. It holds the IF/ID latch and splits the latched instruction into fields. It reads a 32x32 register file with write-back bypass, detects load-use hazards, and drives the operand and field inputs of the ID/EX register. On a stall it injects a NOP bubble downstream and freezes the upstream fetch.

Parameters:
WORD_WIDTH, 32, datapath width (matches `WORD_WIDTH in defines.v)
REG_COUNT, 32, number of architectural registers; the address width is 5
CNT_WIDTH, 16, width of the stall-cycle performance counter

Ports:
CLK  input  1  clock; all state updates on posedge
RST_N  input  1  asynchronous active-low reset
IR_in  input  WORD_WIDTH  fetched instruction from the IF stage
PC4_in  input  WORD_WIDTH  PC+4 of the fetched instruction
IF_valid  input  1  IR_in holds a real instruction
flush  input  1  squash the IF/ID contents (taken branch/jump)
RegWrite_WB  input  1  write-back enable
WriteReg_WB  input  5  write-back destination register
WriteData_WB  input  WORD_WIDTH  write-back data
MemRead_EX  input  1  the instruction now in EX is a load
Rt_EX  input  5  destination (rt) of the instruction in EX
A_0, B_0  output  WORD_WIDTH  rs/rt operand values to ID/EX
Out31_26_0, Out5_0_0  output  6  opcode / funct fields to ID/EX
Out25_21_0, Out20_16_0, Out15_11_0, Out10_6_0  output  5  rs, rt, rd, shamt fields to ID/EX
PC4_out  output  WORD_WIDTH  latched PC+4
valid_out  output  1  latched instruction is valid and not bubbled
stall  output  1  hold PC and the IF stage this cycle
stall_cnt  output  CNT_WIDTH  count of stall cycles since reset

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect immediately):
  - IR latch, PC4 latch, valid, all registers and stall_cnt go to 0.
  - All outputs therefore read 0, including stall.
  - Reset asserted mid-operation discards any in-flight instruction. There is no partial write.
- IF/ID latch, evaluated on each posedge:
  - Priority is flush > stall > load.
  - flush=1: IR<=0, valid<=0, PC4<=0.
  - stall=1: IR, PC4 and valid hold their values.
  - Otherwise: IR<=IR_in, PC4<=PC4_in, valid<=IF_valid.
  - flush and stall asserted together: flush wins.
- Field split (combinational from latched IR):
  - opcode = IR[31:26], rs = IR[25:21], rt = IR[20:16], rd = IR[15:11], shamt = IR[10:6], funct = IR[5:0].
- Register file:
  - Write on posedge when RegWrite_WB=1 and WriteReg_WB!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Reads are combinational.
  - Bypass: if RegWrite_WB=1, WriteReg_WB!=0 and WriteReg_WB equals the read address, the read returns WriteData_WB in the same cycle (write-before-read).
- Hazard detection:
  - uses_rt = (opcode==0) | (opcode==4) | (opcode==5) | (opcode==43).
  - stall = valid & MemRead_EX & (Rt_EX!=0) & ((Rt_EX==rs) | (uses_rt & (Rt_EX==rt))).
  - stall is combinational, from the latched IR and the current EX inputs.
- Bubble injection:
  - While stall=1, A_0, B_0, all Out*_0 fields and valid_out are forced to 0. This is sll $0,$0,0, which ID/EX latches as a NOP.
  - PC4_out is not forced.
  - When stall=0, outputs carry the decoded values; valid_out = valid.
- stall_cnt:
  - Increments on each posedge where stall=1 and flush=0.
  - Saturates at all-ones; it does not wrap.
- Latency:
  - One cycle from IR_in to the field outputs.
  - Operands reflect register state including the same-cycle WB bypass.
  - A load-use pair costs exactly one stall cycle, because the load leaves EX on the next edge.

Test Plan:
- Reset, then IR_in=0x012A4020 (add $8,$9,$10) with IF_valid=1 and $9=5, $10=7 preloaded via WB -> after 1 edge: Out31_26_0=0, Out25_21_0=9, Out20_16_0=10, Out15_11_0=8, Out5_0_0=0x20, A_0=5, B_0=7, valid_out=1.
- WB bypass: latched rs=$3 while the same cycle has RegWrite_WB=1, WriteReg_WB=3, WriteData_WB=0xDEADBEEF -> A_0=0xDEADBEEF in that cycle. Repeat with WriteReg_WB=0 -> A_0=0 and $0 unchanged.
- Load-use: latched add uses rs=$4, MemRead_EX=1, Rt_EX=4 -> stall=1, all outputs 0, IR held. Next cycle with MemRead_EX=0 -> stall=0, add is presented, stall_cnt=1.
- No false stall: latched lw $5,0($6) (opcode 35, rt=5), MemRead_EX=1, Rt_EX=5 -> stall=0, because lw does not use rt. Same with Rt_EX=0 -> stall=0.
- flush and stall together on one edge -> next cycle IR=0, valid_out=0, stall_cnt unchanged.
- Assert RST_N low mid-stall (asynchronously) -> stall, stall_cnt and all outputs go to 0 immediately. Drive 2^16+3 stall cycles -> stall_cnt stays at 0xFFFF.
